// File: rtl/ctr_stream_scheduler.sv
// ctr_stream_scheduler: runs one CTR encryption job from key setup to the last
// ciphertext beat. It fires the PRNG/S-box setup strobe, waits for round keys,
// issues plaintext blocks and counter words to the encrypt core, and buffers
// the ciphertext in a small output FIFO toward an AXI-stream style sink.
//
// Handshake rules, on every stream interface: a beat moves on a rising clock
// edge where valid && ready are both high. The sender keeps valid and its data
// steady until that edge. A ready output never depends on the valid input it
// is paired with. The core side has no backpressure. core_tvalid is a
// one-cycle issue strobe. core_valid is a one-cycle result strobe. The core is
// only ever given as much work as the output FIFO can still absorb.
module ctr_stream_scheduler #(
    parameter int DATA_WIDTH    = 256,
    parameter int CNT_WIDTH     = 16,
    parameter int OUT_DEPTH     = 4,
    parameter int SETUP_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_blocks,
    input  logic [DATA_WIDTH-1:0] iv,
    output logic                  setup_tvalid,
    input  logic                  key_done,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  core_tvalid,
    output logic [DATA_WIDTH-1:0] core_plaintext,
    output logic [DATA_WIDTH-1:0] core_ctr,
    input  logic                  core_valid,
    input  logic [DATA_WIDTH-1:0] core_ciphertext,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            debug_state
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int TMO_W = $clog2(SETUP_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SETUP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        WAIT_KEY = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  nb_r;
    logic [DATA_WIDTH-1:0] iv_r;
    logic [CNT_WIDTH-1:0]  issued;
    logic [CNT_WIDTH-1:0]  received;
    logic [CNT_WIDTH-1:0]  popped;
    logic [TMO_W-1:0]      tmo;

    logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    logic [CNT_WIDTH-1:0]  inflight;
    logic [CNT_WIDTH:0]    used;
    logic                  have_credit;
    logic                  s_hs;
    logic                  accept_core;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  overflow;

    // Credit check: FIFO slots already taken plus results still owed by the core.
    always_comb begin
        inflight    = issued - received;
        used        = {1'b0, inflight} + (CNT_WIDTH + 1)'(count);
        have_credit = used < (CNT_WIDTH + 1)'(OUT_DEPTH);
        s_tready    = (state == STREAM) && have_credit && (issued < nb_r);
        s_hs        = s_tvalid && s_tready;
        accept_core = core_valid && ((state == STREAM) || (state == DRAIN));
        fifo_full   = count == (PTR_W + 1)'(OUT_DEPTH);
        m_tvalid    = count != '0;
        pop         = m_tvalid && m_tready;
        push        = accept_core && (!fifo_full || pop);
        overflow    = accept_core && fifo_full && !pop;
        m_tdata     = m_tvalid ? mem[rd_ptr] : '0;
        m_tlast     = m_tvalid && (popped == nb_r - CNT_WIDTH'(1));
        busy        = state != IDLE;
        debug_state = state;
    end

    // Ciphertext storage. The read side is gated by m_tvalid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= core_ciphertext;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Job sequencer: setup strobe, key wait with timeout, block issue, drain, completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            nb_r           <= '0;
            iv_r           <= '0;
            issued         <= '0;
            received       <= '0;
            popped         <= '0;
            tmo            <= '0;
            setup_tvalid   <= 1'b0;
            core_tvalid    <= 1'b0;
            core_plaintext <= '0;
            core_ctr       <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            setup_tvalid <= 1'b0;
            core_tvalid  <= 1'b0;
            done         <= 1'b0;
            if (pop) begin
                popped <= popped + CNT_WIDTH'(1);
            end
            // A dropped word still counts as received, so the drain can complete.
            if (accept_core) begin
                received <= received + CNT_WIDTH'(1);
            end
            if (overflow) begin
                error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        nb_r     <= num_blocks;
                        iv_r     <= iv;
                        issued   <= '0;
                        received <= '0;
                        popped   <= '0;
                        error    <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    setup_tvalid <= 1'b1;
                    tmo          <= '0;
                    state        <= WAIT_KEY;
                end
                WAIT_KEY: begin
                    if (key_done) begin
                        state <= (nb_r == '0) ? DRAIN : STREAM;
                    end else if (tmo == TMO_LAST) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                STREAM: begin
                    // The counter word is a full-width add and wraps silently.
                    if (s_hs) begin
                        core_tvalid    <= 1'b1;
                        core_plaintext <= s_tdata;
                        core_ctr       <= iv_r + DATA_WIDTH'(issued);
                        issued         <= issued + CNT_WIDTH'(1);
                    end
                    if (issued == nb_r) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((received == nb_r) && (count == '0)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_stream_scheduler.sv
// Testbench for ctr_stream_scheduler. It uses a table of jobs plus a few
// hand-written corner sequences. The bench models the encrypt core as a
// fixed-latency XOR of the plaintext with the counter word.
module tb_ctr_stream_scheduler;

    localparam int DW        = 256;
    localparam int CW        = 16;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 100;
    localparam int CORE_LAT  = 3;

    typedef struct {
        logic [CW-1:0] nb;
        logic [DW-1:0] iv;
        int            key_delay;
        int            ready_mode;   // 0: always ready, 1: stall then release, 2: toggle
        logic          exp_error;
        logic [DW-1:0] exp_last_ctr;
    } job_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_blocks;
    logic [DW-1:0] iv;
    logic          setup_tvalid;
    logic          key_done;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic          core_tvalid;
    logic [DW-1:0] core_plaintext;
    logic [DW-1:0] core_ctr;
    logic          core_valid;
    logic [DW-1:0] core_ciphertext;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    debug_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ctr_stream_scheduler #(
        .DATA_WIDTH(DW), .CNT_WIDTH(CW), .OUT_DEPTH(DEPTH), .SETUP_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks), .iv(iv),
        .setup_tvalid(setup_tvalid), .key_done(key_done),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .core_tvalid(core_tvalid), .core_plaintext(core_plaintext), .core_ctr(core_ctr),
        .core_valid(core_valid), .core_ciphertext(core_ciphertext),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .busy(busy), .done(done), .error(error), .debug_state(debug_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [DW-1:0] exp_ctr_q[$];
    logic [DW-1:0] exp_pt_q[$];
    logic [DW-1:0] src_q[$];

    int cyc = 0;
    int setup_cnt = 0, done_cnt = 0, hs_cnt = 0, issue_cnt = 0, beat_cnt = 0, mvalid_cnt = 0;
    int setup_cyc = 0, done_cyc = 0, last_pop_cyc = 0;
    logic [DW-1:0] last_ctr = '0;

    logic          force_core = 1'b0;
    logic [DW-1:0] force_data = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: samples on the falling edge ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (setup_tvalid) begin setup_cnt++; setup_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (s_tvalid && s_tready) hs_cnt++;
            if (m_tvalid) mvalid_cnt++;
            if (core_tvalid) begin
                issue_cnt++;
                last_ctr = core_ctr;
                if (exp_ctr_q.size() == 0) begin
                    check("core_issue_unexpected", DW'(core_tvalid), DW'(0));
                end else begin
                    check("core_ctr", core_ctr, exp_ctr_q.pop_front());
                    check("core_plaintext", core_plaintext, exp_pt_q.pop_front());
                end
            end
            if (m_tvalid && m_tready) begin
                beat_cnt++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("m_beat_unexpected", DW'(m_tvalid), DW'(0));
                end else begin
                    check("m_tdata", m_tdata, exp_q.pop_front());
                    check("m_tlast", DW'(m_tlast), DW'(exp_last_q.pop_front()));
                end
            end
        end
    end

    // ---------------- encrypt core model ----------------
    initial begin
        logic [DW-1:0] pipe_d [CORE_LAT];
        logic          pipe_v [CORE_LAT];
        for (int i = 0; i < CORE_LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        core_valid      = 1'b0;
        core_ciphertext = '0;
        forever begin
            @(negedge clk);
            if (force_core) begin
                core_valid      = 1'b1;
                core_ciphertext = force_data;
            end else begin
                core_valid      = pipe_v[CORE_LAT-1];
                core_ciphertext = pipe_d[CORE_LAT-1];
                for (int i = CORE_LAT - 1; i > 0; i--) begin
                    pipe_v[i] = pipe_v[i-1];
                    pipe_d[i] = pipe_d[i-1];
                end
                pipe_v[0] = core_tvalid;
                pipe_d[0] = core_plaintext ^ core_ctr;
            end
        end
    end

    // ---------------- plaintext source driver ----------------
    initial begin
        bit hs;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                s_tvalid = 1'b1;
                s_tdata  = src_q[0];
            end else begin
                s_tvalid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] make_pt(input int tag, input int i);
        return {8{32'hC0DE_0000 ^ 32'(tag * 256 + i)}};
    endfunction

    task automatic load_job(input logic [CW-1:0] nb, input logic [DW-1:0] v, input int tag);
        logic [DW-1:0] ctr;
        logic [DW-1:0] p;
        ctr = v;
        for (int i = 0; i < int'(nb); i++) begin
            p = make_pt(tag, i);
            src_q.push_back(p);
            exp_pt_q.push_back(p);
            exp_ctr_q.push_back(ctr);
            exp_q.push_back(p ^ ctr);
            exp_last_q.push_back(i == int'(nb) - 1);
            ctr = ctr + DW'(1);
        end
    endtask

    task automatic flush_queues();
        src_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        exp_ctr_q.delete();
        exp_pt_q.delete();
    endtask

    task automatic pulse_start(input logic [CW-1:0] nb, input logic [DW-1:0] v);
        @(posedge clk); #1;
        start = 1'b1; num_blocks = nb; iv = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_setup(input int s0, input string name);
        for (int k = 0; k < 20; k++) begin
            if (setup_cnt != s0) break;
            @(posedge clk); #1;
        end
        check(name, DW'(setup_cnt - s0), DW'(1));
    endtask

    task automatic wait_done(input int s0, input int budget, input bit toggle);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt != s0) break;
            @(posedge clk); #1;
            if (toggle) m_tready = ~m_tready;
        end
    endtask

    task automatic check_zero_outputs(input string p);
        check({p, "_setup_tvalid"}, DW'(setup_tvalid), DW'(0));
        check({p, "_s_tready"}, DW'(s_tready), DW'(0));
        check({p, "_core_tvalid"}, DW'(core_tvalid), DW'(0));
        check({p, "_core_plaintext"}, core_plaintext, DW'(0));
        check({p, "_core_ctr"}, core_ctr, DW'(0));
        check({p, "_m_tvalid"}, DW'(m_tvalid), DW'(0));
        check({p, "_m_tdata"}, m_tdata, DW'(0));
        check({p, "_m_tlast"}, DW'(m_tlast), DW'(0));
        check({p, "_busy"}, DW'(busy), DW'(0));
        check({p, "_done"}, DW'(done), DW'(0));
        check({p, "_error"}, DW'(error), DW'(0));
        check({p, "_state"}, DW'(debug_state), DW'(0));
    endtask

    task automatic run_job(input job_t j, input int tag);
        int s_setup, s_done, s_hs, s_issue, s_beat, s_mv;
        s_setup = setup_cnt; s_done = done_cnt; s_hs = hs_cnt;
        s_issue = issue_cnt; s_beat = beat_cnt; s_mv = mvalid_cnt;
        load_job(j.nb, j.iv, tag);
        m_tready = (j.ready_mode != 1);
        pulse_start(j.nb, j.iv);
        check($sformatf("job%0d_busy", tag), DW'(busy), DW'(1));
        wait_setup(s_setup, $sformatf("job%0d_setup_seen", tag));
        repeat (j.key_delay) @(posedge clk);
        #1 key_done = 1'b1;
        if (j.ready_mode == 1) begin
            repeat (40) @(posedge clk);
            #1;
            check($sformatf("job%0d_stall_issues", tag), DW'(issue_cnt - s_issue), DW'(DEPTH));
            check($sformatf("job%0d_stall_s_tready", tag), DW'(s_tready), DW'(0));
            check($sformatf("job%0d_stall_error", tag), DW'(error), DW'(0));
            // A start while busy must leave the latched job untouched.
            pulse_start(16'd2, '0);
            m_tready = 1'b1;
        end
        wait_done(s_done, 3000, j.ready_mode == 2);
        check($sformatf("job%0d_done_pulses", tag), DW'(done_cnt - s_done), DW'(1));
        check($sformatf("job%0d_error", tag), DW'(error), DW'(j.exp_error));
        check($sformatf("job%0d_beats", tag), DW'(beat_cnt - s_beat), DW'(j.nb));
        check($sformatf("job%0d_handshakes", tag), DW'(hs_cnt - s_hs), DW'(j.nb));
        check($sformatf("job%0d_setup_pulses", tag), DW'(setup_cnt - s_setup), DW'(1));
        check($sformatf("job%0d_leftover", tag), DW'(exp_q.size()), DW'(0));
        if (j.nb != '0) begin
            check($sformatf("job%0d_last_ctr", tag), last_ctr, j.exp_last_ctr);
            // The last pop commits on the edge after its sample; done rises on the next edge.
            check($sformatf("job%0d_done_after_pop", tag), DW'(done_cyc - last_pop_cyc), DW'(2));
        end else begin
            check($sformatf("job%0d_no_m_tvalid", tag), DW'(mvalid_cnt - s_mv), DW'(0));
        end
        key_done = 1'b0;
        m_tready = 1'b0;
        @(posedge clk); #1;
        check($sformatf("job%0d_idle", tag), DW'(busy), DW'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        job_t jobs[5];
        int s0, s1;

        jobs[0].nb = 16'd3; jobs[0].iv = {{248{1'b1}}, 8'hFE}; jobs[0].key_delay = 10;
        jobs[0].ready_mode = 0; jobs[0].exp_error = 1'b0; jobs[0].exp_last_ctr = '0;
        jobs[1].nb = 16'd8; jobs[1].iv = 256'h1000; jobs[1].key_delay = 2;
        jobs[1].ready_mode = 1; jobs[1].exp_error = 1'b0; jobs[1].exp_last_ctr = 256'h1007;
        jobs[2].nb = 16'd0; jobs[2].iv = 256'h55; jobs[2].key_delay = 3;
        jobs[2].ready_mode = 0; jobs[2].exp_error = 1'b0; jobs[2].exp_last_ctr = '0;
        jobs[3].nb = 16'd5; jobs[3].iv = 256'h7; jobs[3].key_delay = 0;
        jobs[3].ready_mode = 2; jobs[3].exp_error = 1'b0; jobs[3].exp_last_ctr = 256'hB;
        jobs[4].nb = 16'd1; jobs[4].iv = {256{1'b1}}; jobs[4].key_delay = 1;
        jobs[4].ready_mode = 0; jobs[4].exp_error = 1'b0; jobs[4].exp_last_ctr = {256{1'b1}};

        reset = 1'b1; start = 1'b0; num_blocks = '0; iv = '0;
        key_done = 1'b0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 5; t++) begin
            run_job(jobs[t], t);
        end

        // Setup timeout: key_done never arrives.
        s0 = setup_cnt; s1 = done_cnt;
        pulse_start(16'd2, 256'h99);
        wait_setup(s0, "tmo_setup_seen");
        wait_done(s1, 300, 1'b0);
        check("tmo_done_pulses", DW'(done_cnt - s1), DW'(1));
        check("tmo_done_cycle", DW'(done_cyc - setup_cyc), DW'(TIMEOUT));
        check("tmo_error", DW'(error), DW'(1));
        check("tmo_busy", DW'(busy), DW'(0));
        pulse_start(16'd0, 256'h0);
        check("tmo_error_cleared", DW'(error), DW'(0));
        s1 = done_cnt;
        key_done = 1'b1;
        wait_done(s1, 50, 1'b0);
        check("tmo_recover_done", DW'(done_cnt - s1), DW'(1));
        key_done = 1'b0;
        repeat (2) @(posedge clk);

        // Core result while the FIFO is full: dropped, flagged, FIFO intact.
        s0 = setup_cnt; s1 = issue_cnt;
        load_job(16'd5, 256'h200, 10);
        m_tready = 1'b0;
        pulse_start(16'd5, 256'h200);
        wait_setup(s0, "ovf_setup_seen");
        #1 key_done = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("ovf_issues", DW'(issue_cnt - s1), DW'(DEPTH));
        check("ovf_pre_error", DW'(error), DW'(0));
        force_data = {256{1'b1}};
        force_core = 1'b1;
        @(posedge clk); #1 force_core = 1'b0;
        @(posedge clk); #1;
        check("ovf_error", DW'(error), DW'(1));
        check("ovf_head_data", m_tdata, exp_q[0]);
        s0 = beat_cnt;
        m_tready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("ovf_beats", DW'(beat_cnt - s0), DW'(DEPTH));
        check("ovf_empty", DW'(m_tvalid), DW'(0));
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        key_done = 1'b0; m_tready = 1'b0;
        flush_queues();
        repeat (4) @(posedge clk);

        // Reset in the middle of a stream with blocks still inside the core.
        s0 = setup_cnt; s1 = issue_cnt;
        load_job(16'd6, 256'h300, 11);
        pulse_start(16'd6, 256'h300);
        wait_setup(s0, "mid_setup_seen");
        #1 key_done = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (issue_cnt - s1 >= 2) break;
            @(posedge clk); #1;
        end
        check("mid_issued_before_reset", DW'(issue_cnt - s1 >= 2), DW'(1));
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b0; key_done = 1'b0;
        flush_queues();
        s0 = mvalid_cnt;
        m_tready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_no_m_tvalid", DW'(mvalid_cnt - s0), DW'(0));
        check("mid_busy", DW'(busy), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
